l1_refill_ctrl: RTL and testbench
=================================

Name: l1_refill_ctrl

Overview:
- Miss-side writer for the L1 tag and data arrays.
- On a lookup miss it captures the miss address and fetches the whole block from next-level memory with a burst request.
- Writes each returned word into the data array, then writes the tag into the round-robin victim way.
- The tag is written last, so a partially filled line can never produce a hit.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (2-bit byte offset).
- SET_NUMBER, 8, number of ways (tag memories); power of 2, >=2.
- BLOCK_NUMBER, 128, total blocks in cache; INDEX_WIDTH = clog2(BLOCK_NUMBER) - clog2(SET_NUMBER).
- BLOCK_SIZE, 32, words per block; power of 2, >=2.

Derived widths:
- BLOCK_NUMBER_LSB = clog2(BLOCK_SIZE) + 2.
- TAG_LSB = BLOCK_NUMBER_LSB + INDEX_WIDTH.
- TAG_WIDTH = ADDR_WIDTH - TAG_LSB.
- WAY_WIDTH = clog2(SET_NUMBER).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_val  in  1  miss request valid
- miss_addr  in  ADDR_WIDTH  missing byte address
- miss_rdy  out  1  controller idle, can accept a miss
- mem_req_val  out  1  block read request valid
- mem_req_addr  out  ADDR_WIDTH  block-aligned address
- mem_req_rdy  in  1  memory accepts request
- mem_resp_val  in  1  response beat valid
- mem_resp_data  in  DATA_WIDTH  response word (in order, word 0 first)
- data_wr_val  out  1  data array write enable
- data_wr_addr  out  ADDR_WIDTH  cache-side address {0, way, index, beat, 2'b00}
- data_wr_data  out  DATA_WIDTH  word to write
- tag_wr_val  out  1  tag write enable
- tag_wr_addr  out  ADDR_WIDTH  {0, way, index, BLOCK_NUMBER_LSB zeros}
- tag_wr_data  out  TAG_WIDTH  captured miss tag
- refill_done  out  1  one-cycle pulse, refill complete

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- During rst: state=IDLE, beat counter=0, victim pointer=0, captured address=0. All outputs 0, including miss_rdy.
- States: IDLE, REQ, FILL, TAG.
- IDLE:
  - miss_rdy=1.
  - miss_val & miss_rdy captures miss_addr[ADDR_WIDTH-1:BLOCK_NUMBER_LSB] -> REQ.
- REQ:
  - mem_req_val=1; mem_req_addr={captured, BLOCK_NUMBER_LSB zeros}, held stable until accepted.
  - mem_req_val & mem_req_rdy -> FILL, beat=0.
  - mem_resp_val in REQ is ignored (protocol violation).
- FILL:
  - data_wr_val = mem_resp_val, combinational same-cycle passthrough.
  - data_wr_data = mem_resp_data.
  - data_wr_addr way = victim pointer, index = captured index, word field = beat.
  - Each valid beat increments beat.
  - Valid beat with beat==BLOCK_SIZE-1 -> TAG.
  - Idle cycles (mem_resp_val=0) hold state.
- TAG (exactly 1 cycle):
  - tag_wr_val=1, refill_done=1, tag_wr_data = captured tag.
  - Victim pointer increments, wrapping SET_NUMBER-1 -> 0.
  - Next state IDLE.
- Output timing and idle values:
  - miss_rdy=0 in every state except IDLE.
  - Back-to-back misses: the earliest next acceptance is the cycle after TAG.
  - Outside their active state, data_wr_*, tag_wr_*, mem_req_* and refill_done drive 0.
- Latency: with mem_req_rdy=1 immediately and one beat per cycle:
  - Miss accepted at cycle 0.
  - mem_req_val at cycle 1.
  - Beats at cycles 2..BLOCK_SIZE+1.
  - tag_wr_val/refill_done at cycle BLOCK_SIZE+2.
- mem_resp_val in IDLE or TAG is ignored: no write, no state change.
- rst asserted mid-refill:
  - Aborts the refill and returns to IDLE; victim pointer resets to 0.
  - No tag write occurs for the aborted fill.
  - Partial data words may remain in the array, but they are unreachable because no tag is written.
  - Beats arriving after reset are ignored.
- Victim pointer advances only on a completed TAG write.

Test Plan (defaults: INDEX_WIDTH=4, TAG_LSB=11, TAG_WIDTH=21):
- Single miss after reset: miss_addr=0x00001A84, mem_req_rdy=1, 32 back-to-back beats data=beat index.
  - mem_req_addr=0x00001A80 at cycle 1.
  - data_wr_addr 0x280..0x2FC step 4, data 0..31.
  - Cycle 34: tag_wr_val=1, tag_wr_addr=0x280, tag_wr_data=3, refill_done=1.
  - Cycle 35: miss_rdy=1.
- Second miss to same address: victim way 1 -> data_wr_addr 0xA80..0xAFC, tag_wr_addr=0xA80.
- Nine consecutive refills: ways 0..7 then 0, confirming pointer wrap.
- mem_req_rdy low 5 cycles, and mem_resp_val toggled 1/0 in FILL:
  - mem_req_val/addr stable until accept.
  - Exactly 32 writes, beat only advances on valid; single tag write.
- rst asserted after 10 beats:
  - No tag_wr_val, outputs 0, IDLE afterwards.
  - Stray mem_resp_val produces no data_wr_val.
  - Next miss uses way 0.
- miss_val held high through a whole refill: only one capture; a second miss is accepted exactly the cycle after refill_done.

Source files
------------

// File: rtl/l1_refill_ctrl_if.sv
// Bus bundle between the L1 refill controller and its miss source,
// next-level memory, and the tag/data array write ports.
interface l1_refill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 21
);
    logic                  miss_val;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  miss_rdy;
    logic                  mem_req_val;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_rdy;
    logic                  mem_resp_val;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic                  data_wr_val;
    logic [ADDR_WIDTH-1:0] data_wr_addr;
    logic [DATA_WIDTH-1:0] data_wr_data;
    logic                  tag_wr_val;
    logic [ADDR_WIDTH-1:0] tag_wr_addr;
    logic [TAG_WIDTH-1:0]  tag_wr_data;
    logic                  refill_done;

    // Controller side
    modport master (
        input  miss_val, miss_addr, mem_req_rdy, mem_resp_val, mem_resp_data,
        output miss_rdy, mem_req_val, mem_req_addr, data_wr_val, data_wr_addr,
               data_wr_data, tag_wr_val, tag_wr_addr, tag_wr_data, refill_done
    );

    // Environment side (miss source, memory, arrays)
    modport slave (
        output miss_val, miss_addr, mem_req_rdy, mem_resp_val, mem_resp_data,
        input  miss_rdy, mem_req_val, mem_req_addr, data_wr_val, data_wr_addr,
               data_wr_data, tag_wr_val, tag_wr_addr, tag_wr_data, refill_done
    );
endinterface

// File: rtl/l1_refill_ctrl.sv
// L1 miss-side refill controller: fetches a whole block from next-level
// memory, writes every word into the data array, then commits the tag into
// the round-robin victim way last so a partial line can never hit.
module l1_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SET_NUMBER   = 8,
    parameter int unsigned BLOCK_NUMBER = 128,
    parameter int unsigned BLOCK_SIZE   = 32
) (
    input logic              clk,
    input logic              rst,
    l1_refill_ctrl_if.master bus
);
    localparam int unsigned INDEX_WIDTH      = $clog2(BLOCK_NUMBER) - $clog2(SET_NUMBER);
    localparam int unsigned BLOCK_NUMBER_LSB = $clog2(BLOCK_SIZE) + 2;
    localparam int unsigned TAG_LSB          = BLOCK_NUMBER_LSB + INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH        = ADDR_WIDTH - TAG_LSB;
    localparam int unsigned WAY_WIDTH        = $clog2(SET_NUMBER);
    localparam int unsigned BEAT_WIDTH       = $clog2(BLOCK_SIZE);
    localparam int unsigned LINE_WIDTH       = ADDR_WIDTH - BLOCK_NUMBER_LSB;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] TAG  = 2'd3;

    logic [1:0]            state, state_next;
    logic [BEAT_WIDTH-1:0] beat, beat_next;
    logic [WAY_WIDTH-1:0]  victim, victim_next;
    logic [LINE_WIDTH-1:0] line, line_next;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] resp_word;
    logic                  unused_offset;

    assign index         = line[INDEX_WIDTH-1:0];
    assign tag           = line[LINE_WIDTH-1:INDEX_WIDTH];
    assign resp_word     = bus.mem_resp_data;
    // Byte/word offset of the miss address is irrelevant: whole block is fetched
    assign unused_offset = ^bus.miss_addr[BLOCK_NUMBER_LSB-1:0];

    // Next-state and output decode; all outputs forced low while rst is high
    always_comb begin
        state_next       = state;
        beat_next        = beat;
        victim_next      = victim;
        line_next        = line;
        bus.miss_rdy     = 1'b0;
        bus.mem_req_val  = 1'b0;
        bus.mem_req_addr = '0;
        bus.data_wr_val  = 1'b0;
        bus.data_wr_addr = '0;
        bus.data_wr_data = '0;
        bus.tag_wr_val   = 1'b0;
        bus.tag_wr_addr  = '0;
        bus.tag_wr_data  = '0;
        bus.refill_done  = 1'b0;

        case (state)
            IDLE: begin
                bus.miss_rdy = 1'b1;
                if (bus.miss_val) begin
                    line_next  = bus.miss_addr[ADDR_WIDTH-1:BLOCK_NUMBER_LSB];
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.mem_req_val  = 1'b1;
                bus.mem_req_addr = {line, {BLOCK_NUMBER_LSB{1'b0}}};
                if (bus.mem_req_rdy) begin
                    beat_next  = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.data_wr_val  = bus.mem_resp_val;
                bus.data_wr_data = resp_word;
                bus.data_wr_addr = ADDR_WIDTH'({victim, index, beat, 2'b00});
                if (bus.mem_resp_val) begin
                    beat_next = beat + BEAT_WIDTH'(1);
                    if (beat == BEAT_WIDTH'(BLOCK_SIZE - 1)) begin
                        state_next = TAG;
                    end
                end
            end
            TAG: begin
                bus.tag_wr_val  = 1'b1;
                bus.refill_done = 1'b1;
                bus.tag_wr_data = tag;
                bus.tag_wr_addr = ADDR_WIDTH'({victim, index, {BLOCK_NUMBER_LSB{1'b0}}});
                victim_next     = victim + WAY_WIDTH'(1);
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (rst) begin
            bus.miss_rdy     = 1'b0;
            bus.mem_req_val  = 1'b0;
            bus.mem_req_addr = '0;
            bus.data_wr_val  = 1'b0;
            bus.data_wr_addr = '0;
            bus.data_wr_data = '0;
            bus.tag_wr_val   = 1'b0;
            bus.tag_wr_addr  = '0;
            bus.tag_wr_data  = '0;
            bus.refill_done  = 1'b0;
        end
    end

    // State, beat counter, victim pointer and captured line address
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            victim <= '0;
            line   <= '0;
        end else begin
            state  <= state_next;
            beat   <= beat_next;
            victim <= victim_next;
            line   <= line_next;
        end
    end
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Randomized self-checking bench for l1_refill_ctrl against a
// transaction-level model of where each refill word and tag must land.
module tb_l1_refill_ctrl;
    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned SET_NUMBER   = 8;
    localparam int unsigned BLOCK_NUMBER = 128;
    localparam int unsigned BLOCK_SIZE   = 32;
    localparam int unsigned IDX_SETS     = BLOCK_NUMBER / SET_NUMBER;
    localparam int unsigned LINE_BYTES   = BLOCK_SIZE * 4;
    localparam int unsigned TAG_W        = ADDR_WIDTH - $clog2(LINE_BYTES * IDX_SETS);

    logic clk;
    logic rst;
    int unsigned n_vec;
    int unsigned n_miss;
    int unsigned ref_way;

    l1_refill_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_W)) bus ();

    l1_refill_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SET_NUMBER  (SET_NUMBER),
        .BLOCK_NUMBER(BLOCK_NUMBER),
        .BLOCK_SIZE  (BLOCK_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Model: cache geometry from plain arithmetic on the byte address
    function automatic logic [31:0] exp_req_addr(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int unsigned exp_set(input logic [31:0] a);
        return (a / LINE_BYTES) % IDX_SETS;
    endfunction

    function automatic logic [31:0] exp_tag(input logic [31:0] a);
        return a / (LINE_BYTES * IDX_SETS);
    endfunction

    function automatic logic [31:0] exp_wr_addr(input logic [31:0] a, input int unsigned way,
                                                input int unsigned bt);
        return 32'(((way * IDX_SETS + exp_set(a)) * BLOCK_SIZE + bt) * 4);
    endfunction

    function automatic logic [31:0] exp_tag_addr(input logic [31:0] a, input int unsigned way);
        return 32'((way * IDX_SETS + exp_set(a)) * LINE_BYTES);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_miss_rdy"}, 64'(bus.miss_rdy), 64'd0);
        check({tag, "_req_val"}, 64'(bus.mem_req_val), 64'd0);
        check({tag, "_wr_val"}, 64'(bus.data_wr_val), 64'd0);
        check({tag, "_tag_val"}, 64'(bus.tag_wr_val), 64'd0);
        check({tag, "_done"}, 64'(bus.refill_done), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.miss_val = 1'b0;
        bus.mem_resp_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet("rst");
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.mem_resp_val = 1'b0;
        ref_way = 0;
    endtask

    // One full refill; abort_at >= 0 asserts rst after that many beats
    task automatic refill(input logic [31:0] addr, input int stall, input bit gaps,
                          input bit rand_data, input bit hold, input int abort_at);
        int          bt;
        int          idle_run;
        bit          v;
        logic [31:0] d;

        bus.miss_val  = 1'b1;
        bus.miss_addr = addr;
        @(negedge clk);
        check("miss_rdy_idle", 64'(bus.miss_rdy), 64'd1);
        check("req_val_idle", 64'(bus.mem_req_val), 64'd0);
        @(posedge clk); #1;
        bus.miss_val = hold;
        if (!hold) bus.miss_addr = $urandom;

        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_rdy  = (i == stall);
            bus.mem_resp_val = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("req_val", 64'(bus.mem_req_val), 64'd1);
            check("req_addr", 64'(bus.mem_req_addr), 64'(exp_req_addr(addr)));
            check("miss_rdy_busy", 64'(bus.miss_rdy), 64'd0);
            check("wr_val_req", 64'(bus.data_wr_val), 64'd0);
            @(posedge clk); #1;
        end
        bus.mem_req_rdy = 1'b0;

        bt = 0;
        idle_run = 0;
        while (bt < int'(BLOCK_SIZE)) begin
            if (abort_at >= 0 && bt == abort_at) break;
            v = !gaps || ($urandom_range(0, 1) == 1) || (idle_run >= 4);
            d = rand_data ? $urandom : 32'(bt);
            bus.mem_resp_val  = v;
            bus.mem_resp_data = d;
            @(negedge clk);
            check("wr_val", 64'(bus.data_wr_val), 64'(v));
            if (v) begin
                check("wr_addr", 64'(bus.data_wr_addr), 64'(exp_wr_addr(addr, ref_way, bt)));
                check("wr_data", 64'(bus.data_wr_data), 64'(d));
            end
            check("tag_val_fill", 64'(bus.tag_wr_val), 64'd0);
            check("req_val_fill", 64'(bus.mem_req_val), 64'd0);
            check("miss_rdy_fill", 64'(bus.miss_rdy), 64'd0);
            @(posedge clk); #1;
            if (v) begin
                bt++;
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end

        if (abort_at >= 0) begin
            rst = 1'b1;
            bus.mem_resp_val = 1'b1;
            @(negedge clk);
            check_quiet("abort");
            @(posedge clk); #1;
            rst = 1'b0;
            ref_way = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("stray_wr_val", 64'(bus.data_wr_val), 64'd0);
                check("stray_tag_val", 64'(bus.tag_wr_val), 64'd0);
                check("stray_miss_rdy", 64'(bus.miss_rdy), 64'd1);
                @(posedge clk); #1;
            end
            bus.mem_resp_val = 1'b0;
            return;
        end

        bus.mem_resp_val  = 1'($urandom_range(0, 1));
        bus.mem_resp_data = $urandom;
        @(negedge clk);
        check("tag_val", 64'(bus.tag_wr_val), 64'd1);
        check("done", 64'(bus.refill_done), 64'd1);
        check("tag_addr", 64'(bus.tag_wr_addr), 64'(exp_tag_addr(addr, ref_way)));
        check("tag_data", 64'(bus.tag_wr_data), 64'(exp_tag(addr)));
        check("wr_val_tag", 64'(bus.data_wr_val), 64'd0);
        check("miss_rdy_tag", 64'(bus.miss_rdy), 64'd0);
        @(posedge clk); #1;
        bus.mem_resp_val = 1'b0;
        ref_way = (ref_way + 1) % SET_NUMBER;

        if (!hold) begin
            @(negedge clk);
            check("miss_rdy_after", 64'(bus.miss_rdy), 64'd1);
            check("done_after", 64'(bus.refill_done), 64'd0);
            check("tag_val_after", 64'(bus.tag_wr_val), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        ref_way = 0;
        rst = 1'b1;
        bus.miss_val = 1'b0;
        bus.miss_addr = '0;
        bus.mem_req_rdy = 1'b0;
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_data = '0;
        @(posedge clk); #1;

        do_reset();
        refill(32'h0000_1A84, 0, 1'b0, 1'b0, 1'b0, -1);
        refill(32'h0000_1A84, 0, 1'b0, 1'b0, 1'b0, -1);

        do_reset();
        for (int i = 0; i < 9; i++) refill($urandom, 0, 1'b0, 1'b1, 1'b0, -1);

        refill($urandom, 5, 1'b1, 1'b1, 1'b0, -1);

        refill($urandom, 0, 1'b0, 1'b1, 1'b0, 10);
        refill(32'h0000_1A84, 0, 1'b0, 1'b0, 1'b0, -1);

        refill($urandom, 0, 1'b0, 1'b1, 1'b1, -1);
        refill($urandom, 0, 1'b0, 1'b1, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            refill($urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b1,
                   1'($urandom_range(0, 1)), -1);
        end
        refill($urandom, 2, 1'b1, 1'b1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
